dma2d_read_master: RTL and testbench

AXI4 read master forming the source half of the 2D DMA path. It fetches a rectangular image region (width bytes × height lines, line pitch = stride) from memory in INCR bursts and pushes each returned beat into the transfer FIFO. The write master drains that FIFO toward the destination. Bursts are capped at 64 B, never cross a line end, and never cross a 4 KB boundary.

---
 rtl/dma2d_read_master.sv | 148 ++++++++++++++
 tb/tb_dma2d_read_master.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dma2d_read_master.sv
// Purpose : AXI4 read master for the 2D DMA source path. It fetches width x height bytes
//           at line pitch stride, in INCR bursts of at most 64 B. A burst never crosses a
//           line end or a 4 KB page.
// Latency : i_start -> arvalid 2 cycles; rlast beat -> next arvalid 2 cycles; beats reach the FIFO in the same cycle.
// Backpr. : a burst is issued only once i_fifo_space covers all of its beats, so rready is never withdrawn.
// Ports   : clk/reset_n; i_start + image geometry in; o_read_done/o_busy/o_rresp_err status;
//           i_fifo_space, o_fifo_wr_en/o_fifo_wdata to the transfer FIFO; m_axi_ar*/m_axi_r* read channels.
module dma2d_read_master #(
  parameter int C_M_AXI_ADDR_WIDTH = 32,
  parameter int C_M_AXI_DATA_WIDTH = 32
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          i_start,
  input  logic [31:0]                   i_src_addr,
  input  logic [31:0]                   i_img_width,
  input  logic [31:0]                   i_img_height,
  input  logic [31:0]                   i_img_stride,
  output logic                          o_read_done,
  output logic                          o_busy,
  output logic                          o_rresp_err,
  input  logic [15:0]                   i_fifo_space,
  output logic                          o_fifo_wr_en,
  output logic [C_M_AXI_DATA_WIDTH-1:0] o_fifo_wdata,
  output logic [C_M_AXI_ADDR_WIDTH-1:0] m_axi_araddr,
  output logic [7:0]                    m_axi_arlen,
  output logic [2:0]                    m_axi_arsize,
  output logic [1:0]                    m_axi_arburst,
  output logic                          m_axi_arvalid,
  input  logic                          m_axi_arready,
  input  logic [C_M_AXI_DATA_WIDTH-1:0] m_axi_rdata,
  input  logic [1:0]                    m_axi_rresp,
  input  logic                          m_axi_rlast,
  input  logic                          m_axi_rvalid,
  output logic                          m_axi_rready
);

  typedef enum logic [1:0] {IDLE, CALC, AR_PHASE, R_PHASE} state_t;

  state_t      state, state_nxt;
  logic [31:0] width_q, height_q, stride_q;
  logic [31:0] cur_addr, line_start, line_done, line_cnt, burst_bytes;
  logic [7:0]  arlen_q;
  logic        read_done_q, rresp_err_q;

  logic [31:0] rem_line, rem_page, calc_bytes, calc_beats;
  logic        space_ok, beat, last_beat, line_end, final_line, start_ok, empty_job;

  // Burst size: the smallest of the 64 B cap, the bytes left in the line and the bytes left in the 4 KB page.
  always_comb begin
    rem_line   = width_q - line_done;
    rem_page   = 32'h0000_1000 - {20'd0, cur_addr[11:0]};
    calc_bytes = 32'd64;
    if (rem_line < calc_bytes) calc_bytes = rem_line;
    if (rem_page < calc_bytes) calc_bytes = rem_page;
    calc_beats = calc_bytes >> 2;
  end

  assign space_ok   = {16'd0, i_fifo_space} >= calc_beats;
  assign beat       = m_axi_rvalid & m_axi_rready;
  assign last_beat  = beat & m_axi_rlast;
  assign line_end   = (line_done + burst_bytes) >= width_q;
  assign final_line = line_cnt == (height_q - 32'd1);
  assign start_ok   = (state == IDLE) && i_start;
  assign empty_job  = (i_img_width == 32'd0) || (i_img_height == 32'd0);

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // Next-state logic. rlast alone ends a burst; no beat counter is kept.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (i_start && !empty_job) state_nxt = CALC;
      CALC:     if (space_ok) state_nxt = AR_PHASE;
      AR_PHASE: if (m_axi_arready) state_nxt = R_PHASE;
      R_PHASE:  if (last_beat) state_nxt = (line_end && final_line) ? IDLE : CALC;
      default:  state_nxt = IDLE;
    endcase
  end

  // Output decode on the registered state
  always_comb begin
    m_axi_arvalid = (state == AR_PHASE);
    m_axi_rready  = (state == R_PHASE);
    o_busy        = (state != IDLE);
  end

  // Datapath registers. cur_addr and arlen_q only change outside AR_PHASE,
  // so the AR payload stays stable until arready.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      width_q     <= '0;
      height_q    <= '0;
      stride_q    <= '0;
      cur_addr    <= '0;
      line_start  <= '0;
      line_done   <= '0;
      line_cnt    <= '0;
      burst_bytes <= '0;
      arlen_q     <= '0;
      read_done_q <= 1'b0;
      rresp_err_q <= 1'b0;
    end else begin
      if (start_ok) begin
        width_q     <= i_img_width;
        height_q    <= i_img_height;
        stride_q    <= i_img_stride;
        cur_addr    <= i_src_addr;
        line_start  <= i_src_addr;
        line_done   <= '0;
        line_cnt    <= '0;
        read_done_q <= empty_job;
        rresp_err_q <= 1'b0;
      end
      if (state == CALC) begin
        burst_bytes <= calc_bytes;
        arlen_q     <= calc_beats[7:0] - 8'd1;
      end
      if (beat && (m_axi_rresp != 2'b00)) rresp_err_q <= 1'b1;
      if ((state == R_PHASE) && last_beat) begin
        if (line_end) begin
          line_start <= line_start + stride_q;
          cur_addr   <= line_start + stride_q;
          line_done  <= '0;
          line_cnt   <= line_cnt + 32'd1;
          if (final_line) read_done_q <= 1'b1;
        end else begin
          cur_addr  <= cur_addr + burst_bytes;
          line_done <= line_done + burst_bytes;
        end
      end
    end
  end

  assign m_axi_araddr  = cur_addr[C_M_AXI_ADDR_WIDTH-1:0];
  assign m_axi_arlen   = arlen_q;
  assign m_axi_arsize  = 3'b010;
  assign m_axi_arburst = 2'b01;
  assign o_fifo_wr_en  = beat;
  assign o_fifo_wdata  = m_axi_rdata;
  assign o_read_done   = read_done_q;
  assign o_rresp_err   = rresp_err_q;

endmodule

// File: tb/tb_dma2d_read_master.sv
// Bench for dma2d_read_master: a table of image geometries with hand-computed AR
// sequences and push counts, plus sequences for rresp error, FIFO stall and reset.
module tb_dma2d_read_master;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        i_start;
  logic [31:0] i_src_addr, i_img_width, i_img_height, i_img_stride;
  logic        o_read_done, o_busy, o_rresp_err;
  logic [15:0] i_fifo_space;
  logic        o_fifo_wr_en;
  logic [31:0] o_fifo_wdata;
  logic [31:0] m_axi_araddr;
  logic [7:0]  m_axi_arlen;
  logic [2:0]  m_axi_arsize;
  logic [1:0]  m_axi_arburst;
  logic        m_axi_arvalid, m_axi_arready;
  logic [31:0] m_axi_rdata;
  logic [1:0]  m_axi_rresp;
  logic        m_axi_rlast, m_axi_rvalid, m_axi_rready;

  dma2d_read_master dut (
    .clk(clk), .reset_n(reset_n), .i_start(i_start), .i_src_addr(i_src_addr),
    .i_img_width(i_img_width), .i_img_height(i_img_height), .i_img_stride(i_img_stride),
    .o_read_done(o_read_done), .o_busy(o_busy), .o_rresp_err(o_rresp_err),
    .i_fifo_space(i_fifo_space), .o_fifo_wr_en(o_fifo_wr_en), .o_fifo_wdata(o_fifo_wdata),
    .m_axi_araddr(m_axi_araddr), .m_axi_arlen(m_axi_arlen), .m_axi_arsize(m_axi_arsize),
    .m_axi_arburst(m_axi_arburst), .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
    .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp), .m_axi_rlast(m_axi_rlast),
    .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0]      src;
    logic [31:0]      width;
    logic [31:0]      height;
    logic [31:0]      stride;
    logic [31:0]      n_ar;
    logic [7:0][31:0] ar_addr;
    logic [7:0][7:0]  ar_len;
    logic [31:0]      pushes;
  } vec_t;

  localparam int NV = 6;
  vec_t vecs [NV];

  int tests = 0;
  int fails = 0;

  // Observations collected by the slave model
  int          pushes, n_ar, data_bad, gap_bad, first_ar, r_left, beat_no, stall_bad;
  logic [31:0] r_addr;
  logic [31:0] ar_a [16];
  logic [7:0]  ar_l [16];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic clear_rec();
    pushes = 0; n_ar = 0; data_bad = 0; gap_bad = 0; first_ar = -1;
    r_left = 0; beat_no = 0; r_addr = '0;
  endtask

  // Pulses i_start for one cycle; returns at a falling edge.
  task automatic start_xfer(input logic [31:0] src, input logic [31:0] w,
                            input logic [31:0] h, input logic [31:0] s);
    @(negedge clk);
    i_src_addr = src; i_img_width = w; i_img_height = h; i_img_stride = s; i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
  endtask

  // AXI read slave: rdata is the byte address of the beat, and rresp is 2'b10 on beat err_beat of each burst.
  // Runs until o_read_done, until stop_pushes pushes (if > 0), or until a cycle budget expires.
  task automatic service(input int err_beat, input int stop_pushes);
    int cyc;
    int last_rl;
    cyc = 0;
    last_rl = -100;
    m_axi_arready = 1'b1;
    forever begin
      if (r_left > 0) begin
        m_axi_rvalid = 1'b1;
        m_axi_rdata  = r_addr;
        m_axi_rlast  = (r_left == 1);
        m_axi_rresp  = (beat_no == err_beat) ? 2'b10 : 2'b00;
      end else begin
        m_axi_rvalid = 1'b0;
        m_axi_rlast  = 1'b0;
        m_axi_rresp  = 2'b00;
      end
      #1;
      if (o_fifo_wr_en) begin
        pushes++;
        if (o_fifo_wdata !== m_axi_rdata) data_bad++;
        if (m_axi_rlast) last_rl = cyc;
        r_left--;
        r_addr = r_addr + 32'd4;
        beat_no++;
      end
      if (m_axi_arvalid && m_axi_arready) begin
        if (n_ar < 16) begin
          ar_a[n_ar] = m_axi_araddr;
          ar_l[n_ar] = m_axi_arlen;
        end
        if (n_ar == 0) first_ar = cyc;
        else if (cyc - last_rl != 2) gap_bad++;
        n_ar++;
        r_left  = int'(m_axi_arlen) + 1;
        r_addr  = m_axi_araddr;
        beat_no = 0;
      end
      if (o_read_done) break;
      if (stop_pushes > 0 && pushes >= stop_pushes) break;
      if (cyc >= 3000) begin
        tests++; fails++;
        $display("FAIL service_timeout: got no o_read_done within %0d cycles, required done", cyc);
        break;
      end
      @(negedge clk);
      cyc++;
    end
  endtask

  initial begin
    // Vector table: geometry, expected AR sequence, expected push count.
    vecs[0] = '0; vecs[0].src = 32'h1000; vecs[0].width = 64; vecs[0].height = 1; vecs[0].stride = 64;
    vecs[0].n_ar = 1; vecs[0].ar_addr[0] = 32'h1000; vecs[0].ar_len[0] = 15; vecs[0].pushes = 16;

    vecs[1] = '0; vecs[1].src = 32'h0FF0; vecs[1].width = 64; vecs[1].height = 1; vecs[1].stride = 64;
    vecs[1].n_ar = 2; vecs[1].pushes = 16;
    vecs[1].ar_addr[0] = 32'h0FF0; vecs[1].ar_len[0] = 3;
    vecs[1].ar_addr[1] = 32'h1000; vecs[1].ar_len[1] = 11;

    vecs[2] = '0; vecs[2].src = 32'h2000; vecs[2].width = 100; vecs[2].height = 3; vecs[2].stride = 256;
    vecs[2].n_ar = 6; vecs[2].pushes = 75;
    vecs[2].ar_addr[0] = 32'h2000; vecs[2].ar_len[0] = 15;
    vecs[2].ar_addr[1] = 32'h2040; vecs[2].ar_len[1] = 8;
    vecs[2].ar_addr[2] = 32'h2100; vecs[2].ar_len[2] = 15;
    vecs[2].ar_addr[3] = 32'h2140; vecs[2].ar_len[3] = 8;
    vecs[2].ar_addr[4] = 32'h2200; vecs[2].ar_len[4] = 15;
    vecs[2].ar_addr[5] = 32'h2240; vecs[2].ar_len[5] = 8;

    vecs[3] = '0; vecs[3].src = 32'h3000; vecs[3].width = 0; vecs[3].height = 2; vecs[3].stride = 64;

    vecs[4] = '0; vecs[4].src = 32'h3000; vecs[4].width = 64; vecs[4].height = 0; vecs[4].stride = 64;

    vecs[5] = '0; vecs[5].src = 32'h0FFC; vecs[5].width = 12; vecs[5].height = 2; vecs[5].stride = 32'h1000;
    vecs[5].n_ar = 4; vecs[5].pushes = 6;
    vecs[5].ar_addr[0] = 32'h0FFC; vecs[5].ar_len[0] = 0;
    vecs[5].ar_addr[1] = 32'h1000; vecs[5].ar_len[1] = 1;
    vecs[5].ar_addr[2] = 32'h1FFC; vecs[5].ar_len[2] = 0;
    vecs[5].ar_addr[3] = 32'h2000; vecs[5].ar_len[3] = 1;

    // Reset state
    reset_n = 1'b0; i_start = 1'b0; i_src_addr = '0; i_img_width = '0; i_img_height = '0;
    i_img_stride = '0; i_fifo_space = 16'd100; m_axi_arready = 1'b1; m_axi_rdata = '0;
    m_axi_rresp = 2'b00; m_axi_rlast = 1'b0; m_axi_rvalid = 1'b0;
    clear_rec();
    repeat (3) @(negedge clk);
    chk("rst arvalid", {31'd0, m_axi_arvalid}, 0);
    chk("rst rready", {31'd0, m_axi_rready}, 0);
    chk("rst busy", {31'd0, o_busy}, 0);
    chk("rst done", {31'd0, o_read_done}, 0);
    chk("rst araddr", m_axi_araddr, 0);
    chk("rst arlen", {24'd0, m_axi_arlen}, 0);
    chk("arsize", {29'd0, m_axi_arsize}, 3'b010);
    chk("arburst", {30'd0, m_axi_arburst}, 2'b01);
    reset_n = 1'b1;

    // Table-driven transfers
    for (int i = 0; i < NV; i++) begin
      clear_rec();
      start_xfer(vecs[i].src, vecs[i].width, vecs[i].height, vecs[i].stride);
      service(-1, 0);
      chk($sformatf("v%0d n_ar", i), n_ar, vecs[i].n_ar);
      for (int k = 0; k < int'(vecs[i].n_ar) && k < n_ar; k++) begin
        chk($sformatf("v%0d araddr%0d", i, k), ar_a[k], vecs[i].ar_addr[k]);
        chk($sformatf("v%0d arlen%0d", i, k), {24'd0, ar_l[k]}, {24'd0, vecs[i].ar_len[k]});
      end
      chk($sformatf("v%0d pushes", i), pushes, vecs[i].pushes);
      chk($sformatf("v%0d wdata", i), data_bad, 0);
      chk($sformatf("v%0d rlast_to_ar", i), gap_bad, 0);
      if (vecs[i].n_ar > 0) chk($sformatf("v%0d start_to_ar", i), first_ar, 1);
      chk($sformatf("v%0d done", i), {31'd0, o_read_done}, 1);
      chk($sformatf("v%0d busy", i), {31'd0, o_busy}, 0);
      chk($sformatf("v%0d rresp_err", i), {31'd0, o_rresp_err}, 0);
    end

    // Error response on the third beat: flag is sticky and the burst still completes
    clear_rec();
    start_xfer(32'h1000, 64, 1, 64);
    service(2, 0);
    chk("err flag", {31'd0, o_rresp_err}, 1);
    chk("err pushes", pushes, 16);
    chk("err done", {31'd0, o_read_done}, 1);
    clear_rec();
    start_xfer(32'h1000, 64, 1, 64);
    #1;
    chk("err cleared by start", {31'd0, o_rresp_err}, 0);
    chk("done cleared by start", {31'd0, o_read_done}, 0);
    service(-1, 0);
    chk("err stays clear", {31'd0, o_rresp_err}, 0);

    // FIFO stall: no AR while space is short; AR one cycle after space is raised
    clear_rec();
    stall_bad = 0;
    i_fifo_space = 16'd10;
    m_axi_arready = 1'b0;
    start_xfer(32'h1000, 64, 1, 64);
    repeat (20) begin
      #1;
      if (m_axi_arvalid) stall_bad++;
      @(negedge clk);
    end
    chk("stall no arvalid", stall_bad, 0);
    chk("stall busy", {31'd0, o_busy}, 1);
    i_fifo_space = 16'd16;
    #1;
    chk("stall arvalid same cycle", {31'd0, m_axi_arvalid}, 0);
    @(negedge clk);
    #1;
    chk("stall arvalid next cycle", {31'd0, m_axi_arvalid}, 1);
    repeat (3) @(negedge clk);
    #1;
    chk("ar held arvalid", {31'd0, m_axi_arvalid}, 1);
    chk("ar held araddr", m_axi_araddr, 32'h1000);
    chk("ar held arlen", {24'd0, m_axi_arlen}, 15);
    service(-1, 0);
    chk("stall pushes", pushes, 16);
    chk("stall done", {31'd0, o_read_done}, 1);
    i_fifo_space = 16'd100;

    // Asynchronous reset in the middle of the R phase
    clear_rec();
    start_xfer(32'h1000, 64, 1, 64);
    service(-1, 5);
    #1 reset_n = 1'b0;
    #1;
    chk("arst rready", {31'd0, m_axi_rready}, 0);
    chk("arst wr_en", {31'd0, o_fifo_wr_en}, 0);
    chk("arst busy", {31'd0, o_busy}, 0);
    chk("arst araddr", m_axi_araddr, 0);
    chk("arst arlen", {24'd0, m_axi_arlen}, 0);
    chk("arst done", {31'd0, o_read_done}, 0);
    m_axi_rvalid = 1'b0; m_axi_rlast = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    clear_rec();
    start_xfer(32'h1000, 64, 1, 64);
    service(-1, 0);
    chk("post-reset pushes", pushes, 16);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
